fault_coverage_tracker: RTL and testbench
=========================================

# fault_coverage_tracker

Synthesizable coverage bookkeeper sitting directly downstream of the per-fault good/faulty output comparison in the c3540 random test generation flow. Per candidate random vector, it consumes one good/faulty response pair per injected fault and keeps a current-vector detection bitmap and an accumulated bitmap. It decides whether to keep the vector and tracks integer coverage percent. It also halves the new-fault threshold at each coverage step and asserts done at the target coverage or after too many consecutive useless vectors.

## Interface
- NUM_FAULTS, 2230, faults in the fault list, indexed 1..NUM_FAULTS
- OUT_W, 22, width of compared circuit outputs
- UT_LIMIT, 20, consecutive rejected vectors before giving up
- DESIRED_COV, 90, target coverage percent
- STEP, 20, coverage step (percent) at which the threshold halves
- IDX_W, 12, fault index / counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; (re)initialise the run from any state
- vec_start  in  1  pulse; a new candidate vector begins (accepted in VEC_WAIT only)
- flt_valid  in  1  one fault result present this cycle (accepted in SIM only)
- flt_idx  in  IDX_W  fault index of this result
- good_out  in  OUT_W  fault-free circuit outputs
- faulty_out  in  OUT_W  fault-injected circuit outputs
- vec_end  in  1  pulse; last fault result for this vector has been delivered
- vec_ready  out  1  high in VEC_WAIT
- decision_valid  out  1  one-cycle pulse carrying keep
- keep  out  1  vector kept; valid with decision_valid
- detected_at  out  IDX_W  accumulated detected faults
- coverage_pct  out  7  floor(100*detected_at/NUM_FAULTS)
- exp_count  out  IDX_W  current new-fault threshold
- kept_cnt, total_cnt  out  16 each  kept / tried vectors, saturating
- err_idx  out  1  sticky: out-of-range index seen
- done  out  1  run finished; held until start

## Operation
- States: IDLE, VEC_WAIT, SIM, DECIDE, COV, EDGE, CHECK, DONE.
- IDLE: all outputs 0 and vec_ready 0. start enters VEC_WAIT.
- start, from any state: clears the AT bitmap, detected_at, coverage_pct, counters, err_idx and done. Sets exp_count=NUM_FAULTS/20 (111), cov_edg=STEP and ut=0. Next state is VEC_WAIT.
- VEC_WAIT: vec_start clears the CT bitmap, new_cnt and det_ct, increments ut and total_cnt, and enters SIM.
- SIM, on flt_valid with 1<=flt_idx<=NUM_FAULTS and good_out!=faulty_out:
  - Set CT[idx].
  - If CT[idx] was 0, increment det_ct.
  - If CT[idx] was 0 and AT[idx]==0, increment new_cnt.
- Duplicate indices count once per vector.
- Out-of-range flt_idx (0 or >NUM_FAULTS): the result is ignored and err_idx is set.
- vec_end enters DECIDE. If flt_valid and vec_end arrive in the same cycle, the fault is processed first.
- DECIDE: keep = (new_cnt >= exp_count) && (new_cnt > 0). Pulse decision_valid.
  - Keep: AT |= CT, detected_at += new_cnt, kept_cnt++, ut=0, next state COV.
  - Reject: next state CHECK.
- COV: pct starts at 0. Each cycle, if 100*detected_at >= (pct+1)*NUM_FAULTS then pct++, else latch coverage_pct and go to EDGE. Products use IDX_W+7 bits.
- EDGE: if coverage_pct >= cov_edg, then cov_edg += STEP and exp_count >>= 1. At most one halving per kept vector. Next state CHECK.
- CHECK: if coverage_pct >= DESIRED_COV or ut >= UT_LIMIT, go to DONE; else VEC_WAIT.
- DONE: done=1, vec_ready=0, all inputs except start ignored.
- Inputs arriving outside their accepting state are ignored without error.

## Timing
- rst: asynchronous assert, registered release. State IDLE; every output 0, including exp_count and the bitmaps.
- vec_start to state SIM: 1 cycle. One fault result is accepted per cycle at full rate.
- vec_end to decision_valid: 1 cycle (registered in DECIDE).
- Keep path DECIDE to vec_ready: 1 + (coverage_pct+1) + 1 + 1 cycles.
- Reject path DECIDE to vec_ready: 2 cycles.
- Counters saturate and never wrap. detected_at ≤ NUM_FAULTS by construction.
- start has priority over every other input in the same cycle.

## Test plan
- Reset mid-SIM: assert rst with 50 faults logged. Required: immediately IDLE, all outputs 0, and no decision_valid after release.
- start, then vector A detects faults 1..200, then vec_end. Required: keep=1 (200>=111), detected_at=200, coverage_pct=8, kept_cnt=1, exp_count=111.
- Vector B re-detects 1..200. Required: keep=0, detected_at=200, total_cnt=2.
- Cumulative detection reaches 446. Required: coverage_pct=20, exp_count 111→55, next halving only at 40%.
- After one keep, 20 vectors with no detections. Required: done=1 after the 20th decision, coverage_pct unchanged, vec_ready=0.
- Within one vector, report idx 5 twice, plus idx 0 and 2231, all mismatching. Required: new_cnt=1, err_idx=1, keep=0 (1<111).

Source files
------------

// File: rtl/fault_coverage_tracker.sv
// Coverage bookkeeper for random test generation: per-vector and accumulated fault
// detection bitmaps, keep/reject decision, integer coverage and threshold halving.
module fault_coverage_tracker #(
  parameter int NUM_FAULTS  = 2230,
  parameter int OUT_W       = 22,
  parameter int UT_LIMIT    = 20,
  parameter int DESIRED_COV = 90,
  parameter int STEP        = 20,
  parameter int IDX_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_start,
  input  logic             flt_valid,
  input  logic [IDX_W-1:0] flt_idx,
  input  logic [OUT_W-1:0] good_out,
  input  logic [OUT_W-1:0] faulty_out,
  input  logic             vec_end,
  output logic             vec_ready,
  output logic             decision_valid,
  output logic             keep,
  output logic [IDX_W-1:0] detected_at,
  output logic [6:0]       coverage_pct,
  output logic [IDX_W-1:0] exp_count,
  output logic [15:0]      kept_cnt,
  output logic [15:0]      total_cnt,
  output logic             err_idx,
  output logic             done
);

  // state    | meaning
  // IDLE     | after reset, waiting for start   VEC_WAIT | ready for a new vector
  // SIM      | collecting fault results         DECIDE   | keep/reject the vector
  // COV      | iterative coverage percent       EDGE     | threshold halving step
  // CHECK    | termination test                 DONE     | run finished, wait for start
  typedef enum logic [2:0] {
    IDLE, VEC_WAIT, SIM, DECIDE, COV, EDGE, CHECK, DONE
  } state_t;

  localparam int PW = IDX_W + 7;
  localparam logic [IDX_W-1:0] EXP_INIT = IDX_W'(NUM_FAULTS / 20);

  state_t state, state_nxt;

  logic [NUM_FAULTS-1:0] at_map, ct_map;
  logic [IDX_W-1:0]      new_cnt, det_ct, ut_cnt;
  logic [6:0]            pct, cov_edg;
  logic [IDX_W-1:0]      idx0;
  logic                  idx_ok, mism, ct_was, at_was, keep_cond, cov_more;
  logic [PW-1:0]         cov_lhs, cov_rhs;

  assign idx_ok    = (flt_idx >= IDX_W'(1)) && (flt_idx <= IDX_W'(NUM_FAULTS));
  assign idx0      = flt_idx - IDX_W'(1);
  assign mism      = (good_out != faulty_out);
  assign ct_was    = ct_map[idx0];
  assign at_was    = at_map[idx0];
  assign keep_cond = (new_cnt >= exp_count) && (new_cnt != '0);
  assign cov_lhs   = PW'(detected_at) * PW'(100);
  assign cov_rhs   = (PW'(pct) + PW'(1)) * PW'(NUM_FAULTS);
  assign cov_more  = (cov_lhs >= cov_rhs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    vec_ready      = 1'b0;
    decision_valid = 1'b0;
    keep           = 1'b0;
    done           = 1'b0;
    if (start) begin
      state_nxt = VEC_WAIT;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        VEC_WAIT: if (vec_start) state_nxt = SIM;
        SIM:      if (vec_end) state_nxt = DECIDE;
        DECIDE:   state_nxt = keep_cond ? COV : CHECK;
        COV:      if (!cov_more) state_nxt = EDGE;
        EDGE:     state_nxt = CHECK;
        CHECK: begin
          if ((coverage_pct >= 7'(DESIRED_COV)) || (ut_cnt >= IDX_W'(UT_LIMIT)))
            state_nxt = DONE;
          else
            state_nxt = VEC_WAIT;
        end
        DONE:     state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
    case (state)
      VEC_WAIT: vec_ready = 1'b1;
      DECIDE: begin
        decision_valid = 1'b1;
        keep           = keep_cond;
      end
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_map       <= '0;
      ct_map       <= '0;
      new_cnt      <= '0;
      det_ct       <= '0;
      ut_cnt       <= '0;
      pct          <= '0;
      cov_edg      <= '0;
      detected_at  <= '0;
      coverage_pct <= '0;
      exp_count    <= '0;
      kept_cnt     <= '0;
      total_cnt    <= '0;
      err_idx      <= 1'b0;
    end else if (start) begin
      at_map       <= '0;
      ct_map       <= '0;
      new_cnt      <= '0;
      det_ct       <= '0;
      ut_cnt       <= '0;
      pct          <= '0;
      cov_edg      <= 7'(STEP);
      detected_at  <= '0;
      coverage_pct <= '0;
      exp_count    <= EXP_INIT;
      kept_cnt     <= '0;
      total_cnt    <= '0;
      err_idx      <= 1'b0;
    end else begin
      case (state)
        VEC_WAIT: begin
          if (vec_start) begin
            ct_map  <= '0;
            new_cnt <= '0;
            det_ct  <= '0;
            if (ut_cnt != '1)    ut_cnt    <= ut_cnt + IDX_W'(1);
            if (total_cnt != '1) total_cnt <= total_cnt + 16'd1;
          end
        end
        SIM: begin
          if (flt_valid) begin
            if (!idx_ok) begin
              err_idx <= 1'b1;
            end else if (mism) begin
              ct_map[idx0] <= 1'b1;
              // A fault counts once per vector, and only as new if never accumulated.
              if (!ct_was) begin
                det_ct <= det_ct + IDX_W'(1);
                if (!at_was) new_cnt <= new_cnt + IDX_W'(1);
              end
            end
          end
        end
        DECIDE: begin
          pct <= '0;
          if (keep_cond) begin
            at_map      <= at_map | ct_map;
            detected_at <= detected_at + new_cnt;
            ut_cnt      <= '0;
            if (kept_cnt != '1) kept_cnt <= kept_cnt + 16'd1;
          end
        end
        COV: begin
          if (cov_more) pct <= pct + 7'd1;
          else          coverage_pct <= pct;
        end
        EDGE: begin
          if (coverage_pct >= cov_edg) begin
            cov_edg   <= cov_edg + 7'(STEP);
            exp_count <= exp_count >> 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_coverage_tracker.sv
// Directed bench for fault_coverage_tracker: reset, keep/reject, coverage steps,
// threshold halving, duplicate/out-of-range indices and give-up termination.
module tb_fault_coverage_tracker;

  logic        clk = 1'b0;
  logic        rst, start, vec_start, flt_valid, vec_end;
  logic [11:0] flt_idx;
  logic [21:0] good_out, faulty_out;
  logic        vec_ready, decision_valid, keep, err_idx, done;
  logic [11:0] detected_at, exp_count;
  logic [6:0]  coverage_pct;
  logic [15:0] kept_cnt, total_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fault_coverage_tracker dut (
    .clk(clk), .rst(rst), .start(start), .vec_start(vec_start),
    .flt_valid(flt_valid), .flt_idx(flt_idx), .good_out(good_out),
    .faulty_out(faulty_out), .vec_end(vec_end), .vec_ready(vec_ready),
    .decision_valid(decision_valid), .keep(keep), .detected_at(detected_at),
    .coverage_pct(coverage_pct), .exp_count(exp_count), .kept_cnt(kept_cnt),
    .total_cnt(total_cnt), .err_idx(err_idx), .done(done)
  );

  task do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task wait_ready(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (vec_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task begin_vec();
    int c;
    bit ok;
    wait_ready(c, ok);
    vec_start = 1'b1;
    @(negedge clk);
    vec_start = 1'b0;
  endtask

  task send(input int idx, input bit mis, input bit last);
    flt_valid  = 1'b1;
    flt_idx    = idx[11:0];
    good_out   = 22'h2A5A5A;
    faulty_out = mis ? 22'h2A5A5B : 22'h2A5A5A;
    vec_end    = last;
    @(negedge clk);
    flt_valid = 1'b0;
    vec_end   = 1'b0;
  endtask

  task end_vec();
    vec_end = 1'b1;
    @(negedge clk);
    vec_end = 1'b0;
  endtask

  task wait_dec(output bit dv, output bit kp);
    dv = 1'b0;
    kp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (decision_valid === 1'b1) begin
        dv = 1'b1;
        kp = keep;
        break;
      end
      @(negedge clk);
    end
  endtask

  task run_range(input int lo, input int hi, output bit dv, output bit kp);
    begin_vec();
    for (int i = lo; i <= hi; i++) send(i, 1'b1, i == hi);
    wait_dec(dv, kp);
  endtask

  task test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({vec_ready, decision_valid, keep, err_idx, done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {vec_ready, decision_valid, keep, err_idx, done});
    end
    tests++;
    if ({detected_at, exp_count, coverage_pct, kept_cnt, total_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_values: det=%0d exp=%0d cov=%0d kept=%0d tot=%0d expected all 0",
               detected_at, exp_count, coverage_pct, kept_cnt, total_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (vec_ready !== 1'b0 || exp_count !== 12'd0) begin
      fails++;
      $display("FAIL idle_after_reset: vec_ready=%b exp=%0d expected 0 0", vec_ready, exp_count);
    end
  endtask

  task test_reset_mid_sim();
    bit saw_dv;
    do_start();
    begin_vec();
    for (int i = 1; i <= 50; i++) send(i, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({vec_ready, decision_valid, done, err_idx} !== 4'b0 || exp_count !== 12'd0 ||
        total_cnt !== 16'd0 || detected_at !== 12'd0) begin
      fails++;
      $display("FAIL mid_sim_reset: rdy=%b dv=%b exp=%0d tot=%0d det=%0d expected all 0",
               vec_ready, decision_valid, exp_count, total_cnt, detected_at);
    end
    @(negedge clk);
    rst = 1'b0;
    vec_end = 1'b1;
    @(negedge clk);
    vec_end = 1'b0;
    saw_dv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (decision_valid !== 1'b0 || vec_ready !== 1'b0) saw_dv = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (saw_dv !== 1'b0) begin
      fails++;
      $display("FAIL no_decision_after_reset: got activity=%b expected 0", saw_dv);
    end
  endtask

  task test_keep_a();
    bit dv, kp, ok;
    int cyc;
    do_start();
    tests++;
    if (exp_count !== 12'd111 || vec_ready !== 1'b1 || err_idx !== 1'b0) begin
      fails++;
      $display("FAIL start_init: exp=%0d rdy=%b err=%b expected 111 1 0", exp_count, vec_ready, err_idx);
    end
    run_range(1, 200, dv, kp);
    tests++;
    if (dv !== 1'b1 || kp !== 1'b1) begin
      fails++;
      $display("FAIL keep_a: dv=%b keep=%b expected 1 1", dv, kp);
    end
    wait_ready(cyc, ok);
    tests++;
    if (!ok || cyc !== 12) begin
      fails++;
      $display("FAIL keep_latency: got %0d cycles expected 12", cyc);
    end
    tests++;
    if (detected_at !== 12'd200 || coverage_pct !== 7'd8 || kept_cnt !== 16'd1 ||
        exp_count !== 12'd111 || total_cnt !== 16'd1) begin
      fails++;
      $display("FAIL after_a: det=%0d cov=%0d kept=%0d exp=%0d tot=%0d expected 200 8 1 111 1",
               detected_at, coverage_pct, kept_cnt, exp_count, total_cnt);
    end
  endtask

  task test_reject_b();
    bit dv, kp, ok;
    int cyc;
    run_range(1, 200, dv, kp);
    tests++;
    if (dv !== 1'b1 || kp !== 1'b0) begin
      fails++;
      $display("FAIL reject_b: dv=%b keep=%b expected 1 0", dv, kp);
    end
    wait_ready(cyc, ok);
    tests++;
    if (!ok || cyc !== 2) begin
      fails++;
      $display("FAIL reject_latency: got %0d cycles expected 2", cyc);
    end
    tests++;
    if (detected_at !== 12'd200 || total_cnt !== 16'd2 || kept_cnt !== 16'd1) begin
      fails++;
      $display("FAIL after_b: det=%0d tot=%0d kept=%0d expected 200 2 1", detected_at, total_cnt, kept_cnt);
    end
  endtask

  task test_halving();
    bit dv, kp, ok;
    int cyc;
    run_range(201, 446, dv, kp);
    wait_ready(cyc, ok);
    tests++;
    if (kp !== 1'b1 || detected_at !== 12'd446 || coverage_pct !== 7'd20 || exp_count !== 12'd55) begin
      fails++;
      $display("FAIL step_20: keep=%b det=%0d cov=%0d exp=%0d expected 1 446 20 55",
               kp, detected_at, coverage_pct, exp_count);
    end
    tests++;
    if (cyc !== 24) begin
      fails++;
      $display("FAIL keep_latency_20: got %0d cycles expected 24", cyc);
    end
    run_range(447, 560, dv, kp);
    wait_ready(cyc, ok);
    tests++;
    if (kp !== 1'b1 || coverage_pct !== 7'd25 || exp_count !== 12'd55) begin
      fails++;
      $display("FAIL no_halve_25: keep=%b cov=%0d exp=%0d expected 1 25 55", kp, coverage_pct, exp_count);
    end
    run_range(561, 892, dv, kp);
    wait_ready(cyc, ok);
    tests++;
    if (kp !== 1'b1 || coverage_pct !== 7'd40 || exp_count !== 12'd27) begin
      fails++;
      $display("FAIL step_40: keep=%b cov=%0d exp=%0d expected 1 40 27", kp, coverage_pct, exp_count);
    end
    run_range(893, 919, dv, kp);
    wait_ready(cyc, ok);
    tests++;
    if (kp !== 1'b1 || detected_at !== 12'd919 || coverage_pct !== 7'd41 || exp_count !== 12'd27) begin
      fails++;
      $display("FAIL keep_equal_thr: keep=%b det=%0d cov=%0d exp=%0d expected 1 919 41 27",
               kp, detected_at, coverage_pct, exp_count);
    end
    run_range(920, 945, dv, kp);
    wait_ready(cyc, ok);
    tests++;
    if (dv !== 1'b1 || kp !== 1'b0 || detected_at !== 12'd919) begin
      fails++;
      $display("FAIL reject_below_thr: dv=%b keep=%b det=%0d expected 1 0 919", dv, kp, detected_at);
    end
  endtask

  task test_dup_and_range();
    bit dv, kp;
    do_start();
    tests++;
    if (err_idx !== 1'b0 || detected_at !== 12'd0 || exp_count !== 12'd111) begin
      fails++;
      $display("FAIL restart_clear: err=%b det=%0d exp=%0d expected 0 0 111", err_idx, detected_at, exp_count);
    end
    begin_vec();
    send(5, 1'b1, 1'b0);
    send(5, 1'b1, 1'b0);
    send(7, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0);
    send(2231, 1'b1, 1'b1);
    wait_dec(dv, kp);
    tests++;
    if (dv !== 1'b1 || kp !== 1'b0 || err_idx !== 1'b1) begin
      fails++;
      $display("FAIL dup_decision: dv=%b keep=%b err=%b expected 1 0 1", dv, kp, err_idx);
    end
    tests++;
    if (dut.new_cnt !== 12'd1) begin
      fails++;
      $display("FAIL dup_new_cnt: got %0d expected 1", dut.new_cnt);
    end
  endtask

  task test_give_up();
    bit dv, kp, ok;
    int cyc;
    run_range(1, 200, dv, kp);
    tests++;
    if (kp !== 1'b1) begin
      fails++;
      $display("FAIL give_up_keep: keep=%b expected 1", kp);
    end
    for (int v = 1; v <= 20; v++) begin
      begin_vec();
      end_vec();
      wait_dec(dv, kp);
      repeat (3) @(negedge clk);
      if (v == 19) begin
        tests++;
        if (done !== 1'b0 || vec_ready !== 1'b1) begin
          fails++;
          $display("FAIL not_done_19: done=%b rdy=%b expected 0 1", done, vec_ready);
        end
      end
    end
    tests++;
    if (done !== 1'b1 || vec_ready !== 1'b0 || coverage_pct !== 7'd8 || detected_at !== 12'd200) begin
      fails++;
      $display("FAIL done_20: done=%b rdy=%b cov=%0d det=%0d expected 1 0 8 200",
               done, vec_ready, coverage_pct, detected_at);
    end
    vec_start = 1'b1;
    @(negedge clk);
    vec_start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b1 || total_cnt !== 16'd22 || kept_cnt !== 16'd1) begin
      fails++;
      $display("FAIL done_hold: done=%b tot=%0d kept=%0d expected 1 22 1", done, total_cnt, kept_cnt);
    end
    do_start();
    tests++;
    if (done !== 1'b0 || vec_ready !== 1'b1 || total_cnt !== 16'd0 || coverage_pct !== 7'd0) begin
      fails++;
      $display("FAIL restart_from_done: done=%b rdy=%b tot=%0d cov=%0d expected 0 1 0 0",
               done, vec_ready, total_cnt, coverage_pct);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vec_start = 1'b0; flt_valid = 1'b0; vec_end = 1'b0;
    flt_idx = '0; good_out = '0; faulty_out = '0;
    test_reset();
    test_reset_mid_sim();
    test_keep_a();
    test_reject_b();
    test_halving();
    test_dup_and_range();
    test_give_up();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
